// File: rtl/obstacle_field_engine.sv
// Obstacle field for the runner levels: NUM_OBS configurable rectangles, advanced one
// slot per clk on each frame tick, with a registered per-pixel hit vector.
module obstacleFieldSlot #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int SPD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfgLoad,
  input  logic             upd,
  input  logic             cfgEn,
  input  logic             cfgAxis,
  input  logic             cfgMode,
  input  logic             cfgDir,
  input  logic [X_W-1:0]   cfgX,
  input  logic [Y_W-1:0]   cfgY,
  input  logic [X_W-1:0]   cfgW,
  input  logic [Y_W-1:0]   cfgH,
  input  logic [X_W-1:0]   cfgLo,
  input  logic [X_W-1:0]   cfgHi,
  input  logic [SPD_W-1:0] cfgSpeed,
  input  logic [X_W-1:0]   xCount,
  input  logic [Y_W-1:0]   yCount,
  output logic             hit
);
  logic             en, axis, mode, dir;
  logic [X_W-1:0]   posX, w, lo, hi;
  logic [Y_W-1:0]   posY, h;
  logic [SPD_W-1:0] spd;
  logic [X_W-1:0]   p, hiE, s, pNext;
  logic             dirNext;
  logic [X_W:0]     xEnd;
  logic [Y_W:0]     yEnd;

  // Every subtraction below is guarded by a compare, so nothing under/overflows.
  always_comb begin
    p       = axis ? X_W'(posY) : posX;
    hiE     = (lo > hi) ? lo : hi;
    s       = X_W'(spd);
    pNext   = p;
    dirNext = dir;
    if (!mode) begin
      if (dir) begin
        if (p <= lo)          pNext = hiE;
        else if (p - lo < s)  pNext = lo;
        else                  pNext = p - s;
      end else begin
        if (p >= hiE)         pNext = lo;
        else if (hiE - p < s) pNext = hiE;
        else                  pNext = p + s;
      end
    end else begin
      if (dir) begin
        if (p <= lo || p - lo <= s) begin
          pNext   = lo;
          dirNext = 1'b0;
        end else begin
          pNext = p - s;
        end
      end else begin
        if (p >= hiE || hiE - p <= s) begin
          pNext   = hiE;
          dirNext = 1'b1;
        end else begin
          pNext = p + s;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= 1'b0;
      axis <= 1'b0;
      mode <= 1'b0;
      dir  <= 1'b0;
      posX <= '0;
      posY <= '0;
      w    <= '0;
      h    <= '0;
      lo   <= '0;
      hi   <= '0;
      spd  <= '0;
    end else if (cfgLoad) begin
      en   <= cfgEn;
      axis <= cfgAxis;
      mode <= cfgMode;
      dir  <= cfgDir;
      posX <= cfgX;
      posY <= cfgY;
      w    <= cfgW;
      h    <= cfgH;
      lo   <= cfgLo;
      hi   <= cfgHi;
      spd  <= cfgSpeed;
    end else if (upd && en && spd != '0) begin
      if (axis) posY <= pNext[Y_W-1:0];
      else      posX <= pNext;
      dir <= dirNext;
    end
  end

  assign xEnd = {1'b0, posX} + {1'b0, w};
  assign yEnd = {1'b0, posY} + {1'b0, h};
  assign hit  = en && (xCount > posX) && ({1'b0, xCount} < xEnd)
                   && (yCount > posY) && ({1'b0, yCount} < yEnd);
endmodule

module obstacle_field_engine #(
  parameter int NUM_OBS = 16,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int SPD_W   = 4,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               pause,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic               cfg_axis,
  input  logic               cfg_mode,
  input  logic               cfg_dir,
  input  logic [X_W-1:0]     cfg_x,
  input  logic [Y_W-1:0]     cfg_y,
  input  logic [X_W-1:0]     cfg_w,
  input  logic [Y_W-1:0]     cfg_h,
  input  logic [X_W-1:0]     cfg_lo,
  input  logic [X_W-1:0]     cfg_hi,
  input  logic [SPD_W-1:0]   cfg_speed,
  input  logic [X_W-1:0]     x_count,
  input  logic [Y_W-1:0]     y_count,
  output logic [NUM_OBS-1:0] blocks,
  output logic               any_hit,
  output logic               busy,
  output logic               done,
  output logic               overrun
);
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, stateNext;
  logic [IDX_W-1:0]   idx, idxNext;
  logic               doneNext;
  logic [NUM_OBS-1:0] hitVec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      done  <= doneNext;
      if (tick && !pause && state == SWEEP) overrun <= 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    doneNext  = 1'b0;
    case (state)
      IDLE: if (tick && !pause) begin
        stateNext = SWEEP;
        idxNext   = '0;
      end
      SWEEP: begin
        idxNext = idx + 1'b1;
        if (idx == IDX_W'(NUM_OBS - 1)) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state == SWEEP);

  for (genvar gi = 0; gi < NUM_OBS; gi++) begin : gSlot
    obstacleFieldSlot #(.X_W(X_W), .Y_W(Y_W), .SPD_W(SPD_W)) uSlot (
      .clk      (clk),
      .rst      (rst),
      .cfgLoad  (cfg_we && cfg_idx == IDX_W'(gi)),
      .upd      (state == SWEEP && idx == IDX_W'(gi)),
      .cfgEn    (cfg_en),
      .cfgAxis  (cfg_axis),
      .cfgMode  (cfg_mode),
      .cfgDir   (cfg_dir),
      .cfgX     (cfg_x),
      .cfgY     (cfg_y),
      .cfgW     (cfg_w),
      .cfgH     (cfg_h),
      .cfgLo    (cfg_lo),
      .cfgHi    (cfg_hi),
      .cfgSpeed (cfg_speed),
      .xCount   (x_count),
      .yCount   (y_count),
      .hit      (hitVec[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blocks  <= '0;
      any_hit <= 1'b0;
    end else begin
      blocks  <= hitVec;
      any_hit <= |hitVec;
    end
  end
endmodule

// File: tb/tb_obstacle_field_engine.sv
// Scoreboard bench for obstacle_field_engine: a plain-integer obstacle model predicts
// hit vectors, status and done timing; a negedge monitor pops and compares.
module tb_obstacle_field_engine;
  localparam int N = 16, XW = 10, YW = 9, SW = 4, IW = 5;

  logic          clk = 1'b0;
  logic          rst, tick, pause, cfg_we, cfg_en, cfg_axis, cfg_mode, cfg_dir;
  logic [IW-1:0] cfg_idx;
  logic [XW-1:0] cfg_x, cfg_w, cfg_lo, cfg_hi, x_count;
  logic [YW-1:0] cfg_y, cfg_h, y_count;
  logic [SW-1:0] cfg_speed;
  logic [N-1:0]  blocks;
  logic          any_hit, busy, done, overrun;

  obstacle_field_engine #(.NUM_OBS(N), .X_W(XW), .Y_W(YW), .SPD_W(SW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_axis(cfg_axis), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi), .cfg_speed(cfg_speed), .x_count(x_count), .y_count(y_count),
    .blocks(blocks), .any_hit(any_hit), .busy(busy), .done(done), .overrun(overrun));

  always #5 clk = ~clk;

  typedef struct { bit en, axis, mode, dir; int x, y, w, h, lo, hi, spd; } slot_t;
  typedef struct { int c; bit st; logic [N-1:0] blk; logic bsy, ovr; } exp_t;

  slot_t m[N];
  exp_t  q[$];
  int    dq[$];
  int    cyc = 0, vectors = 0, errors = 0;
  bit    ovrModel = 0;
  exp_t  mE;
  bit    expDone;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] expHits(int px, int py);
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++)
      r[i] = m[i].en && px > m[i].x && px < m[i].x + m[i].w && py > m[i].y && py < m[i].y + m[i].h;
    return r;
  endfunction

  // Reference: advance every moving slot once, using plain min/max arithmetic.
  task automatic modelStep();
    int p, lo, hi, s;
    for (int i = 0; i < N; i++) begin
      if (!m[i].en || m[i].spd == 0) continue;
      p  = m[i].axis ? m[i].y : m[i].x;
      lo = m[i].lo;
      hi = (m[i].hi < lo) ? lo : m[i].hi;
      s  = m[i].spd;
      if (!m[i].mode) begin
        if (m[i].dir) p = (p <= lo) ? hi : ((p - s < lo) ? lo : p - s);
        else          p = (p >= hi) ? lo : ((p + s > hi) ? hi : p + s);
      end else if (m[i].dir) begin
        if (p - s <= lo) begin p = lo; m[i].dir = 0; end else p = p - s;
      end else begin
        if (p + s >= hi) begin p = hi; m[i].dir = 1; end else p = p + s;
      end
      if (m[i].axis) m[i].y = p % 512; else m[i].x = p;
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c + 1 <= cyc) begin
      mE = q.pop_front();
      vectors++;
      if (mE.c + 1 < cyc) begin
        errors++;
        $display("FAIL stale expectation from cycle %0d at cycle %0d", mE.c, cyc);
      end else if (mE.st) begin
        if (busy !== mE.bsy || overrun !== mE.ovr) begin
          errors++;
          $display("FAIL status cyc %0d: busy=%b overrun=%b, required busy=%b overrun=%b",
                   cyc, busy, overrun, mE.bsy, mE.ovr);
        end
      end else if (blocks !== mE.blk || any_hit !== (|mE.blk)) begin
        errors++;
        $display("FAIL hit cyc %0d pix(%0d,%0d): blocks=%h any_hit=%b, required blocks=%h any_hit=%b",
                 cyc, x_count, y_count, blocks, any_hit, mE.blk, |mE.blk);
      end
    end
    expDone = (dq.size() > 0 && dq[0] == cyc);
    if (expDone) void'(dq.pop_front());
    if (expDone || done !== 1'b0) begin
      vectors++;
      if (done !== expDone) begin
        errors++;
        $display("FAIL done cyc %0d: done=%b, required %b", cyc, done, expDone);
      end
    end
  end

  task automatic probe(int px, int py);
    px = px & 1023;
    py = py & 511;
    @(posedge clk); #1;
    x_count = XW'(px);
    y_count = YW'(py);
    q.push_back('{c: cyc, st: 1'b0, blk: expHits(px, py), bsy: 1'b0, ovr: 1'b0});
  endtask

  task automatic status(bit b);
    @(posedge clk); #1;
    q.push_back('{c: cyc - 1, st: 1'b1, blk: '0, bsy: b, ovr: ovrModel});
  endtask

  task automatic probeAll();
    for (int i = 0; i < N; i++) if (m[i].en) begin
      probe(m[i].x + 1, m[i].y + 1);
      probe(m[i].x, m[i].y + 1);
      probe(m[i].x + m[i].w, m[i].y + m[i].h - 1);
      probe(m[i].x + m[i].w - 1, m[i].y + m[i].h);
    end
    probe($urandom_range(0, 1023), $urandom_range(0, 511));
  endtask

  task automatic cfgWrite(int idx, bit en, bit ax, bit md, bit dr,
                          int x, int y, int w, int h, int lo, int hi, int spd);
    @(posedge clk); #1;
    cfg_we = 1; cfg_idx = IW'(idx); cfg_en = en; cfg_axis = ax; cfg_mode = md; cfg_dir = dr;
    cfg_x = XW'(x); cfg_y = YW'(y); cfg_w = XW'(w); cfg_h = YW'(h);
    cfg_lo = XW'(lo); cfg_hi = XW'(hi); cfg_speed = SW'(spd);
    if (idx < N) m[idx] = '{en: en, axis: ax, mode: md, dir: dr, x: x % 1024, y: y % 512,
                            w: w % 1024, h: h % 512, lo: lo % 1024, hi: hi % 1024, spd: spd % 16};
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic doTick(bit p, bit sweeps);
    @(posedge clk); #1;
    tick = 1; pause = p;
    if (sweeps) begin
      dq.push_back(cyc + 1 + N);
      modelStep();
    end
    @(posedge clk); #1;
    tick = 0; pause = 0;
  endtask

  task automatic tickSweep();
    doTick(0, 1);
    repeat (N + 1) @(posedge clk);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1; tick = 0; cfg_we = 0;
    dq.delete();
    for (int i = 0; i < N; i++) m[i] = '{default: 0};
    ovrModel = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; tick = 0; pause = 0; cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_axis = 0;
    cfg_mode = 0; cfg_dir = 0; cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0;
    cfg_lo = '0; cfg_hi = '0; cfg_speed = '0; x_count = '0; y_count = '0;
    for (int i = 0; i < N; i++) m[i] = '{default: 0};
    repeat (3) @(posedge clk); #1;
    rst = 0;

    // reset state
    status(0);
    probe(0, 0); probe(300, 200); probe(1023, 511);

    // stationary slot 0 and strict bounds
    cfgWrite(0, 1, 0, 0, 0, 165, 125, 412, 281, 0, 0, 0);
    probe(166, 126); probe(165, 126); probe(577, 126); probe(576, 405); probe(200, 406);
    repeat (8) tickSweep();
    probe(166, 126); probe(165, 126);
    status(0);

    // horizontal respawn slot 1, vertical bounce slot 2
    cfgWrite(1, 1, 0, 0, 1, 165, 20, 10, 10, 75, 165, 2);
    cfgWrite(2, 1, 1, 1, 1, 700, 340, 20, 30, 125, 340, 9);
    repeat (24) tickSweep();
    probeAll(); probe(701, 126); probe(701, 125);
    repeat (21) tickSweep();
    probeAll(); probe(76, 21); probe(75, 21);
    tickSweep();
    probeAll(); probe(166, 21);

    // tick while paused: no sweep, no overrun
    doTick(1, 0);
    status(0);
    repeat (N) @(posedge clk);
    status(0);
    probeAll();

    // pause rising mid-sweep does not stop it
    doTick(0, 1);
    pause = 1;
    repeat (N + 1) @(posedge clk); #1;
    pause = 0;
    probeAll();

    // tick while busy: overrun sticks, only one sweep
    doTick(0, 1);
    doTick(0, 0);
    ovrModel = 1;
    status(1);
    repeat (N) @(posedge clk);
    status(0);
    probeAll();

    // config write beats the sweep on the same slot
    cfgWrite(3, 1, 0, 0, 0, 100, 300, 30, 30, 0, 1000, 5);
    doTick(0, 1);
    repeat (2) @(posedge clk);
    cfgWrite(3, 1, 0, 1, 0, 400, 350, 40, 40, 0, 1000, 7);
    repeat (N) @(posedge clk);
    probeAll();
    status(0);

    // out-of-range slot index ignored
    cfgWrite(N, 1, 0, 0, 0, 3, 3, 50, 50, 0, 0, 0);
    probe(10, 10); probeAll();

    // rst mid-sweep clears everything, including overrun and the pending done
    doTick(0, 1);
    repeat (3) @(posedge clk);
    doReset();
    status(0);
    probe(166, 126); probe(410, 360);
    repeat (N + 2) @(posedge clk);

    // randomized configurations and tick patterns
    for (int i = 0; i < N; i++)
      cfgWrite(i, $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 900), $urandom_range(0, 480),
               $urandom_range(2, 120), $urandom_range(2, 100), $urandom_range(0, 1000),
               $urandom_range(0, 1023), $urandom_range(0, 15));
    probeAll();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        7: begin doTick(1, 0); repeat (4) @(posedge clk); end
        8: begin
          doTick(0, 1);
          doTick(0, 0);
          ovrModel = 1;
          repeat (N) @(posedge clk);
        end
        default: tickSweep();
      endcase
      status(0);
      if (it % 4 == 3) probeAll();
    end
    probeAll();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
